// File: rtl/run_sequencer.sv
// Button-started sequencer: issues NUM_RUNS go/done handshakes to a worker on a
// slower clock, with a debounced start button and a per-wait-state timeout.
module run_sequencer #(
    parameter int          DEBOUNCE_CYCLES = 120000,
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'd12000000,
    parameter int          NUM_RUNS        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       done_sig,
    output logic       go,
    output logic       busy,
    output logic [3:0] run_count,
    output logic       error
);

    localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0]     TMO_LAST = TIMEOUT_CYCLES - 24'd1;
    localparam logic [3:0]      RUNS     = 4'(NUM_RUNS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    logic            r_btn_p0, r_btn_p1;
    logic            r_done_p0, r_done_p1, r_done_p2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_db, r_db_prev;
    state_t          r_state, w_next;
    logic [23:0]     r_timer, w_timer_nxt;
    logic [3:0]      r_run_count, w_count_nxt;
    logic            r_go, r_busy, r_error;
    logic            w_press_lvl, w_press, w_done_rise, w_timeout;

    // Synchronizer stage: button idles high (released), done idles low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_p0  <= 1'b1;
            r_btn_p1  <= 1'b1;
            r_done_p0 <= 1'b0;
            r_done_p1 <= 1'b0;
            r_done_p2 <= 1'b0;
        end else begin
            r_btn_p0  <= start_btn;
            r_btn_p1  <= r_btn_p0;
            r_done_p0 <= done_sig;
            r_done_p1 <= r_done_p0;
            r_done_p2 <= r_done_p1;
        end
    end

    assign w_press_lvl = ~r_btn_p1;
    assign w_done_rise = r_done_p1 & ~r_done_p2;

    // Debounce stage: any matching sample restarts the stability count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt  <= '0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
        end else begin
            r_db_prev <= r_db;
            if (w_press_lvl != r_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db     <= w_press_lvl;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press   = r_db & ~r_db_prev;
    assign w_timeout = (r_timer == TMO_LAST);

    always_comb begin
        w_next      = r_state;
        w_timer_nxt = r_timer;
        w_count_nxt = r_run_count;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (w_press) begin
                    w_next      = S_REQ;
                    w_count_nxt = 4'd0;
                    w_timer_nxt = 24'd0;
                end
            end
            S_REQ: begin
                if (w_done_rise) begin
                    w_next      = S_GAP;
                    w_count_nxt = r_run_count + 4'd1;
                    w_timer_nxt = 24'd0;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_timer_nxt = r_timer + 24'd1;
                end
            end
            S_GAP: begin
                if (!r_done_p1) begin
                    w_next      = (r_run_count == RUNS) ? S_IDLE : S_REQ;
                    w_timer_nxt = 24'd0;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_timer_nxt = r_timer + 24'd1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control stage: outputs registered from the next state so they track r_state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= 24'd0;
            r_run_count <= 4'd0;
            r_go        <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_timer     <= w_timer_nxt;
            r_run_count <= w_count_nxt;
            r_go        <= (w_next == S_REQ);
            r_busy      <= (w_next == S_REQ) || (w_next == S_GAP);
            r_error     <= (w_next == S_ERR);
        end
    end

    assign go        = r_go;
    assign busy      = r_busy;
    assign run_count = r_run_count;
    assign error     = r_error;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, NUM_RUNS=3.
module tb_run_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b1;
    logic       done_sig = 1'b0;
    logic       go, busy, error;
    logic [3:0] run_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    run_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (24'd50),
        .NUM_RUNS       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_btn(start_btn),
        .done_sig (done_sig),
        .go       (go),
        .busy     (busy),
        .run_count(run_count),
        .error    (error)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Button goes low; debounced press lands 6 edges later, go rises on the 7th.
    task automatic press(input string tag);
        start_btn = 1'b0;
        tick(6);
        chk({tag, "_go_before"}, 32'(go), 0);
        tick(1);
        chk({tag, "_go"}, 32'(go), 1);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_count"}, 32'(run_count), 0);
    endtask

    // Entered just after go rose; leaves just after go rises again (or IDLE).
    task automatic handshake(input int k, input string tag);
        tick(5);
        done_sig = 1'b1;
        tick(2);
        chk({tag, "_go_hold"}, 32'(go), 1);
        tick(1);
        chk({tag, "_go_drop"}, 32'(go), 0);
        chk({tag, "_count"}, 32'(run_count), k);
        chk({tag, "_busy_gap"}, 32'(busy), 1);
        tick(7);
        done_sig = 1'b0;
        tick(2);
        chk({tag, "_gap_go"}, 32'(go), 0);
        chk({tag, "_gap_busy"}, 32'(busy), 1);
        tick(1);
        if (k < 3) begin
            chk({tag, "_next_go"}, 32'(go), 1);
        end else begin
            chk({tag, "_end_busy"}, 32'(busy), 0);
            chk({tag, "_end_go"}, 32'(go), 0);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_go", 32'(go), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_count", 32'(run_count), 0);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Short glitch on the button is rejected
        start_btn = 1'b0;
        tick(2);
        start_btn = 1'b1;
        tick(10);
        chk("glitch_go", 32'(go), 0);
        chk("glitch_busy", 32'(busy), 0);

        // Full sequence of three handshakes
        press("p1");
        handshake(1, "s1h1");
        handshake(2, "s1h2");
        handshake(3, "s1h3");
        chk("s1_count", 32'(run_count), 3);
        chk("s1_error", 32'(error), 0);
        start_btn = 1'b1;
        tick(10);
        chk("s1_release_busy", 32'(busy), 0);

        // Timeout in REQ: error exactly 50 cycles after go rose
        press("p2");
        tick(49);
        chk("tmo_go_49", 32'(go), 1);
        chk("tmo_err_49", 32'(error), 0);
        tick(1);
        chk("tmo_err_50", 32'(error), 1);
        chk("tmo_go_50", 32'(go), 0);
        chk("tmo_busy_50", 32'(busy), 0);
        chk("tmo_count", 32'(run_count), 0);
        start_btn = 1'b1;
        tick(10);
        chk("tmo_sticky", 32'(error), 1);

        // Recovery from ERR with a new press
        press("p3");
        handshake(1, "s3h1");
        handshake(2, "s3h2");
        handshake(3, "s3h3");
        chk("s3_count", 32'(run_count), 3);
        chk("s3_error", 32'(error), 0);
        start_btn = 1'b1;
        tick(10);

        // Asynchronous reset mid-sequence
        press("p4");
        handshake(1, "s4h1");
        start_btn = 1'b1;
        tick(8);
        chk("pre_rst_go", 32'(go), 1);
        chk("pre_rst_count", 32'(run_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_go", 32'(go), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count", 32'(run_count), 0);
        tick(2);
        rst = 1'b0;
        tick(3);
        done_sig = 1'b1;
        tick(5);
        done_sig = 1'b0;
        tick(5);
        chk("post_rst_count", 32'(run_count), 0);
        chk("post_rst_go", 32'(go), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // Press during REQ ignored; done in IDLE ignored
        press("p5");
        start_btn = 1'b1;
        tick(10);
        start_btn = 1'b0;
        tick(8);
        chk("req_press_go", 32'(go), 1);
        chk("req_press_busy", 32'(busy), 1);
        chk("req_press_count", 32'(run_count), 0);
        handshake(1, "s5h1");
        handshake(2, "s5h2");
        handshake(3, "s5h3");
        done_sig = 1'b1;
        tick(5);
        done_sig = 1'b0;
        tick(5);
        chk("idle_done_count", 32'(run_count), 3);
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_go", 32'(go), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
